// File: rtl/sl_tx_fifo.sv
// SL (SL0/SL1) serial transmitter fed by a small word FIFO.
// Words leave LSB-first with parity, stop, end marker and a programmable idle gap.
module sl_tx_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8,
  parameter int BQ_W       = $clog2(DATA_W) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        flush,
  input  logic [BQ_W-1:0]             cfg_bits,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_parity_odd,
  input  logic [3:0]                  cfg_gap,
  output logic                        sl0,
  output logic                        sl1,
  output logic                        busy,
  output logic                        word_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_BGAP,
    S_PAR,
    S_PGAP,
    S_STOP,
    S_SEND_END,
    S_IGAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  logic [DATA_W-1:0] r_shift;
  logic [BQ_W-1:0]   r_nbits;
  logic [BQ_W-1:0]   r_bit_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_phase_cnt;
  logic [3:0]        r_gap;
  logic [3:0]        r_gap_cnt;
  logic              r_par;

  logic [BQ_W-1:0]   w_nbits;
  logic [DATA_W-1:0] w_mask;
  logic              w_par;
  logic              w_phase_end;
  logic              w_last_bit;
  logic              w_last_gap;

  logic              r_sl0;
  logic              r_sl1;
  logic              r_busy;
  logic              w_sl0;
  logic              w_sl1;

  // ---------------- FIFO ----------------
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_push     = wr_valid && !w_full && !flush;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign wr_ready   = !w_full;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // A pop on the flush edge still hands its word to the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- word setup at pop ----------------
  assign w_nbits = ((cfg_bits == '0) || (cfg_bits > BQ_W'(DATA_W))) ? BQ_W'(DATA_W) : cfg_bits;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign w_mask[gi] = (BQ_W'(gi) < w_nbits);
    end
  endgenerate

  assign w_par = (^(w_head & w_mask)) ^ cfg_parity_odd;

  assign w_phase_end = (r_phase_cnt == r_div);
  assign w_last_bit  = (r_bit_cnt == r_nbits - BQ_W'(1));
  assign w_last_gap  = (r_gap_cnt == r_gap - 4'd1);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    word_done    = 1'b0;
    case (r_state)
      S_IDLE:     if (w_pop) w_state_next = S_DATA;
      S_DATA:     if (w_phase_end) w_state_next = S_BGAP;
      S_BGAP:     if (w_phase_end) w_state_next = w_last_bit ? S_PAR : S_DATA;
      S_PAR:      if (w_phase_end) w_state_next = S_PGAP;
      S_PGAP:     if (w_phase_end) w_state_next = S_STOP;
      S_STOP:     if (w_phase_end) w_state_next = S_SEND_END;
      S_SEND_END: begin
        if (w_phase_end) begin
          word_done    = 1'b1;
          w_state_next = (r_gap != 4'd0) ? S_IGAP : S_IDLE;
        end
      end
      S_IGAP:     if (w_phase_end && w_last_gap) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // ---------------- counters and shift register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_nbits     <= '0;
      r_bit_cnt   <= '0;
      r_div       <= '0;
      r_phase_cnt <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_par       <= 1'b0;
    end else if (w_pop) begin
      r_shift     <= w_head;
      r_nbits     <= w_nbits;
      r_div       <= cfg_div;
      r_gap       <= cfg_gap;
      r_par       <= w_par;
      r_phase_cnt <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else if (r_state != S_IDLE) begin
      r_phase_cnt <= w_phase_end ? '0 : r_phase_cnt + DIV_W'(1);
      if (w_phase_end) begin
        if (r_state == S_DATA) r_shift <= r_shift >> 1;
        if (r_state == S_BGAP) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BQ_W'(1);
        if (r_state == S_IGAP) r_gap_cnt <= w_last_gap ? '0 : r_gap_cnt + 4'd1;
      end
    end
  end

  // ---------------- line encoding ----------------
  always_comb begin
    w_sl0 = 1'b1;
    w_sl1 = 1'b1;
    case (r_state)
      S_DATA: begin
        w_sl0 = r_shift[0];
        w_sl1 = !r_shift[0];
      end
      S_PAR: begin
        w_sl0 = r_par;
        w_sl1 = !r_par;
      end
      S_STOP: begin
        w_sl0 = 1'b0;
        w_sl1 = 1'b0;
      end
      default: begin
        w_sl0 = 1'b1;
        w_sl1 = 1'b1;
      end
    endcase
  end

  // busy is held across the single IDLE clock between back-to-back words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sl0  <= 1'b1;
      r_sl1  <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_sl0  <= w_sl0;
      r_sl1  <= w_sl1;
      r_busy <= (r_state != S_IDLE) || (r_busy && w_pop);
    end
  end

  assign sl0  = r_sl0;
  assign sl1  = r_sl1;
  assign busy = r_busy;

endmodule

// File: doc/sl_tx_fifo.md
# sl_tx_fifo

Parametrised second-generation SL (two-wire SL0/SL1) serial transmitter with an internal word FIFO. It accepts data words over a valid/ready interface, serialises them LSB-first as SL symbols with a parity bit and stop sequence, and sends queued words back-to-back with a programmable inter-word gap. It sits between the bus-side register block and the SL line drivers and replaces the single-word transmitter in new designs.

## Interface
- DATA_W, 32: maximum word width in bits (2..64).
- FIFO_DEPTH, 4: FIFO depth in words; power of two, ≥2.
- DIV_W, 8: width of the phase-length divider.
- BQ_W, $clog2(DATA_W)+1: width of cfg_bits.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_data  in  DATA_W  word to transmit.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO not full; a push occurs on an edge where wr_valid && wr_ready.
- flush  in  1  synchronous FIFO clear; the word in flight completes.
- cfg_bits  in  BQ_W  data bits per word N; 0 or >DATA_W is treated as DATA_W.
- cfg_div  in  DIV_W  phase length P = cfg_div+1 clocks.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_gap  in  4  idle phases inserted after each word (0..15).
- sl0, sl1  out  1  SL line outputs, registered.
- busy  out  1  high from the first data phase to the end of the inter-word gap.
- word_done  out  1  one-cycle pulse on the last clock of a word's SEND_END phase.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy of the FIFO.

## Operation
- Symbols (one phase = P clocks): one = sl0 1/sl1 0; zero = sl0 0/sl1 1; gap = 1/1; stop = 0/0. Idle = 1/1.
- Word frame: for each of N bits, LSB first: data symbol phase, then gap phase. This is followed by a parity symbol phase, a gap phase, a stop phase, a SEND_END phase (1/1), and cfg_gap IGAP phases (1/1).
- Parity bit p makes popcount(data[N-1:0]) + p odd (cfg_parity_odd=1) or even (0).
- FSM states: IDLE, DATA, BGAP, PAR, PGAP, STOP, SEND_END, IGAP.
  - IDLE → DATA when the FIFO is non-empty (pop).
  - DATA → BGAP after P clocks.
  - BGAP → DATA if bits remain, else → PAR.
  - PAR → PGAP → STOP → SEND_END.
  - SEND_END → IGAP if cfg_gap ≠ 0, else → IDLE.
  - IGAP → IDLE after cfg_gap phases.
  - Every transition occurs after exactly P clocks in the current state, except IDLE.
- cfg_bits, cfg_div, cfg_parity_odd and cfg_gap are sampled on the pop edge and held for the whole word. Changes mid-word take effect on the next word.
- The word is latched into a shift register on pop. Parity is computed from the latched word masked to N bits.
- FIFO behaviour:
  - wr_ready = !full. It does not depend on a same-cycle pop.
  - Simultaneous push and pop when non-full and non-empty leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - flush clears the pointers and fifo_level next edge. A push on the same edge as flush is discarded.
- Counters: the phase counter counts 0..cfg_div and wraps. The bit counter counts 0..N-1. The gap counter counts 0..cfg_gap-1.

## Timing
- Reset values: sl0=1, sl1=1, busy=0, word_done=0, wr_ready=1, fifo_level=0, FSM=IDLE. All counters and the FIFO are cleared.
- Reset mid-word: lines return to 1/1 asynchronously and the word is lost.
- Latency: a push on edge t into an empty FIFO with FSM idle causes the pop at edge t+1. The first data symbol and busy=1 appear from edge t+2.
- Word duration = (2N+4+cfg_gap)·P clocks from first data symbol to return to IDLE.
- Back-to-back words: if the FIFO is non-empty at the end of SEND_END/IGAP, the FSM passes through IDLE for exactly 1 clock. Lines stay 1/1 and busy stays 1 during it.
- word_done is asserted on the clock before the FSM leaves SEND_END.
- fifo_level updates one edge after the push or pop.

## Test plan
- Basic frame: DATA_W=32, cfg_bits=4, cfg_div=1, odd parity, cfg_gap=0; push 0x5.
  - Lines per 2-clock phase: one, gap, zero, gap, one, gap, zero, gap, parity=one (p=1), gap, stop, end.
  - word_done once; 24 clocks total.
- Parity modes: cfg_bits=8, word 0x07. Odd gives p=0 (zero symbol); even gives p=1 (one symbol).
- FIFO full and back-to-back: FIFO_DEPTH=4; push 5 words.
  - wr_ready drops after the 4th accepted; the 5th is held until the pop.
  - 5 frames go out with exactly 1 idle clock plus cfg_gap·P between them; fifo_level returns to 0.
- Config edge cases:
  - cfg_bits=0 sends 32 bits.
  - cfg_div=0 gives 1-clock phases.
  - cfg_gap=15 inserts 15·P idle clocks.
  - cfg changed mid-word does not alter that word's frame.
- Flush and simultaneous events:
  - With 3 words queued and one in flight, assert flush together with wr_valid.
  - The in-flight word completes, no further words are sent, and fifo_level=0.
- Reset mid-word: drop rst_n during a DATA phase. Lines go 1/1 immediately, and after release there are no frames until a new push.
